serial_2s_comp_rx: RTL and testbench
====================================

Name: serial_2s_comp_rx

Overview:
- Serial-in, parallel-out two's-complement negator; the receive-side counterpart of the team's parallel-load, serial-shift complementer.
- Accepts a WIDTH-bit operand as an LSB-first bit stream and negates it bit-serially with a Mealy rule.
- Deserializes the result into a parallel register and drives an active-low 7-segment hex display of that register.
- Sits between a serial link or board switch source and the display/LED outputs.

Parameters:
- WIDTH, 4, operand and result width in bits; the display decodes the low 4 bits.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begins a frame; sampled only in IDLE or DONE.
- sin  input  1  serial operand bit, LSB first.
- sin_valid  input  1  qualifies sin; a bit is consumed on each clk edge where sin_valid=1 in SHIFT.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when the last bit has been consumed.
- Y  output  WIDTH  negated result; holds its value outside SHIFT.
- led  output  7  segments a..g (bit6=a), active-low, hex decode of Y[3:0].

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst, and takes priority over every other input.
- Values on reset: state=IDLE, seen_one flag A=0, bit counter=0, Y=0, busy=0, done=0, led=7'b0000001.
- States and transitions:
  - IDLE -> SHIFT on start=1. On that edge: A cleared, counter cleared, Y cleared.
  - SHIFT, on each edge with sin_valid=1:
    - out bit = sin XOR A; A <= A OR sin.
    - Y <= {out, Y[WIDTH-1:1]} (shift right, MSB in).
    - Counter increments.
  - SHIFT, on an edge with sin_valid=0: nothing changes (stall); there is no timeout.
  - SHIFT -> DONE on the edge that consumes bit WIDTH-1. done=1 for exactly the following cycle.
  - DONE -> IDLE after one cycle. If start=1 while in DONE, go directly to SHIFT (back-to-back frames).
- Latency and result: Y holds the full result on the cycle done=1, i.e. WIDTH valid bits after start. Y is stable until the next start.
- start while in SHIFT: ignored; the current frame continues.
- Reset mid-frame: the partial result is discarded and all values return to reset values.
- Arithmetic: result = (2^WIDTH - operand) mod 2^WIDTH.
  - 0 maps to 0.
  - The most negative value maps to itself.
- Display: led is a combinational decode of Y[3:0].
  - Digits 0-9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
  - Digits A-F: 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
- Blocking assignment of Y and mixed load/shift on one edge are not permitted; all state is registered with nonblocking updates.

Optional Feature:
- Macro: NEG_OVERFLOW_EN.
- Defined:
  - Adds an output port ovf (1 bit, reset 0).
  - ovf is set on the DONE transition when the operand was 1 followed by WIDTH-1 zeros, i.e. it received 10..0 in MSB-first notation. That operand's negation overflows.
  - ovf is cleared on the next start.
- Undefined: no ovf port and no overflow-tracking logic.

Decomposition:
- Shared package serial_cmp_pkg:
  - State enum {IDLE, SHIFT, DONE}.
  - The 16-entry active-low 7-segment constant table.
  - Counter width function clog2(WIDTH).
- Sub-module hex_to_7seg: combinational 4-bit to 7-bit active-low decoder. The team's transmit-side complementer reuses it.

Test Plan:
- Operand 5: start, then sin=1,0,1,0 with sin_valid=1 each cycle -> done pulse 4 cycles after start, Y=4'b1011, led=7'b1100000.
- Operand 0: bits 0,0,0,0 -> Y=0, led=7'b0000001. Operand 4'b1000 (bits 0,0,0,1) -> Y=4'b1000, led=7'b0000000; ovf=1 when NEG_OVERFLOW_EN is defined.
- Stall: operand 4'b0110 with sin_valid low for 3 cycles between bits 1 and 2 -> Y=4'b1010, done exactly once, busy high throughout.
- Reset mid-frame: rst=1 after 2 bits -> on the next edge Y=0, busy=0, led=7'b0000001. A fresh frame of operand 1 then gives Y=4'b1111.
- Control corner cases:
  - start asserted during SHIFT -> ignored, result unchanged.
  - start held high in DONE -> the next frame begins with no IDLE cycle.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// rtl/serial_cmp_pkg.sv - shared states, 7-segment table and width helper for the serial complementers
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Active-low segments a..g with bit6 = a, indexed by hex digit.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Ceiling log2, floored at 1 so a counter always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// rtl/hex_to_7seg.sv - combinational 4-bit to active-low 7-segment decoder
module hex_to_7seg
    import serial_cmp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/serial_2s_comp_rx.sv
// rtl/serial_2s_comp_rx.sv - serial-in two's-complement negator with hex display; NEG_OVERFLOW_EN adds ovf
module serial_2s_comp_rx
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sin,
    input  logic             sin_valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic [6:0]       led
`ifdef NEG_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t        state;
    logic          a;
    logic [CW-1:0] cnt;
    logic          out_bit;
    logic          last_bit;
    logic          go;
    logic          take;

    assign go       = start && ((state == IDLE) || (state == DONE));
    assign take     = (state == SHIFT) && sin_valid;
    assign last_bit = (cnt == LAST);
    // Mealy negation: copy bits up to and including the first 1, invert the rest.
    assign out_bit  = sin ^ a;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a     <= 1'b0;
            cnt   <= '0;
            Y     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= SHIFT;
                        a     <= 1'b0;
                        cnt   <= '0;
                        Y     <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    if (sin_valid) begin
                        a   <= a | sin;
                        Y   <= {out_bit, Y[WIDTH-1:1]};
                        cnt <= last_bit ? '0 : cnt + CW'(1);
                        if (last_bit) begin
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    hex_to_7seg u_seg (
        .digit (Y[3:0]),
        .seg   (led)
    );

`ifdef NEG_OVERFLOW_EN
    // Operand 10..0 is exactly: no 1 seen before the final bit, and the final bit is 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (go) begin
            ovf <= 1'b0;
        end else if (take && last_bit) begin
            ovf <= ~a & sin;
        end
    end
`endif

endmodule

// File: tb/tb_serial_2s_comp_rx.sv
// tb/tb_serial_2s_comp_rx.sv - scoreboard bench for serial_2s_comp_rx
module tb_serial_2s_comp_rx;

    logic       clk;
    logic       rst;
    logic       start;
    logic       sin;
    logic       sin_valid;
    logic       busy;
    logic       done;
    logic [3:0] Y;
    logic [6:0] led;
`ifdef NEG_OVERFLOW_EN
    logic       ovf;
`endif

    int n_checks;
    int n_passed;
    int n_done;
    int n_frames;
    logic prev_done;
    logic [3:0] sb_q[$];

    serial_2s_comp_rx #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sin       (sin),
        .sin_valid (sin_valid),
        .busy      (busy),
        .done      (done),
        .Y         (Y),
        .led       (led)
`ifdef NEG_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_passed = n_passed + 1;
        end
    endtask

    function automatic logic [6:0] exp_led(input logic [3:0] v);
        case (v)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    // Scoreboard: pop the operand for each done pulse and compare against the negation model.
    always @(negedge clk) begin
        logic [3:0] op;
        logic [3:0] exp_y;
        if (done) begin
            n_done = n_done + 1;
            check("done_width", {31'd0, prev_done}, 32'd0);
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                op    = sb_q.pop_front();
                exp_y = 4'((16 - int'(op)) % 16);
                check("y_result", {28'd0, Y}, {28'd0, exp_y});
                check("led_result", {25'd0, led}, {25'd0, exp_led(exp_y)});
`ifdef NEG_OVERFLOW_EN
                check("ovf", {31'd0, ovf}, {31'd0, (op == 4'b1000)});
`endif
            end
        end
        prev_done = done;
    end

    // Called at a negedge; start is raised immediately so a call made while done=1 chains frames.
    task automatic send_frame(input logic [3:0] op, input int stall_at, input int stall_n,
                              input bit poke_start, input bit chain);
        start = 1'b1;
        sin_valid = 1'b0;
        sb_q.push_back(op);
        n_frames = n_frames + 1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    sin_valid = 1'b0;
                    sin = 1'b1;
                    @(negedge clk);
                    check("busy_stall", {31'd0, busy}, 32'd1);
                end
            end
            sin       = op[i];
            sin_valid = 1'b1;
            start     = poke_start && (i == 1);
            @(negedge clk);
        end
        sin_valid = 1'b0;
        start     = 1'b0;
        sin       = 1'b0;
        check("done_on_time", {31'd0, done}, 32'd1);
        if (!chain) begin
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_passed  = 0;
        n_done    = 0;
        n_frames  = 0;
        prev_done = 1'b0;
        rst       = 1'b1;
        start     = 1'b0;
        sin       = 1'b0;
        sin_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_y", {28'd0, Y}, 32'd0);
        check("rst_led", {25'd0, led}, 32'h01);
`ifdef NEG_OVERFLOW_EN
        check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        send_frame(4'd5, -1, 0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("y_hold", {28'd0, Y}, 32'hB);
        check("idle_busy", {31'd0, busy}, 32'd0);

        send_frame(4'd0, -1, 0, 1'b0, 1'b0);
        send_frame(4'b1000, -1, 0, 1'b0, 1'b0);
        send_frame(4'b0110, 2, 3, 1'b0, 1'b0);
        send_frame(4'd3, -1, 0, 1'b1, 1'b0);

        // Back-to-back: the next start lands in DONE.
        send_frame(4'd7, -1, 0, 1'b0, 1'b1);
        send_frame(4'd9, -1, 0, 1'b0, 1'b1);
        send_frame(4'hF, -1, 0, 1'b0, 1'b0);

        // Reset after two bits discards the partial frame.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sin = 1'b1;
            sin_valid = 1'b1;
            @(negedge clk);
        end
        sin_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_y", {28'd0, Y}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_led", {25'd0, led}, 32'h01);
        @(negedge clk);
        send_frame(4'd1, -1, 0, 1'b0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            send_frame(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 2)), 1'b0, 1'b0);
        end

        repeat (2) @(negedge clk);
        check("done_count", n_done, n_frames);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
